sync_down_counter: RTL and testbench

Synchronous, loadable, WIDTH-bit down-counter/timer: the counting-down counterpart to the team's ripple up-counter. All flops share one clock, so there is no ripple delay between bits. It supports parallel load, count enable, one-shot or auto-reload mode, and a registered terminal-count pulse. It serves as the programmable interval timer and clock-enable divider in designs that already use the up-counter for event counting.

---
 rtl/sync_down_counter.sv | 85 ++++++++
 tb/tb_sync_down_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sync_down_counter.sv
// Synchronous loadable down-counter / interval timer.
// One-shot or auto-reload mode with a registered terminal-count pulse.
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            q_q      <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        if (load) begin
            q_d      = load_val;
            reload_d = load_val;
            mode_d   = auto_reload;
            state_d  = (load_val != '0) ? RUN : IDLE;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    if (en) begin
                        // q==1 is decoded explicitly, so q never wraps below 0
                        if (q_q == WIDTH'(1)) begin
                            done_d = 1'b1;
                            if (mode_q) begin
                                q_d = reload_q;
                            end else begin
                                q_d     = '0;
                                state_d = IDLE;
                            end
                        end else begin
                            q_d = q_q - WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign q    = q_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
    assign zero = (q_q == '0);

endmodule

// File: tb/tb_sync_down_counter.sv
// Self-checking bench for sync_down_counter: directed scenarios
// plus randomized traffic against a behavioural timer model.
module tb_sync_down_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, load, auto_reload, en;
    logic [W-1:0] load_val;
    logic [W-1:0] q;
    logic         busy, done, zero;

    int errors = 0;
    int checks = 0;

    int m_q, m_rel, m_done;
    bit m_mode, m_run;

    sync_down_counter #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .load_val(load_val),
        .auto_reload(auto_reload),
        .en(en),
        .q(q),
        .busy(busy),
        .done(done),
        .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Timer behaviour: remaining count, reload value, mode, running flag.
    task automatic model(input bit r, input bit ld, input int v,
                         input bit ar, input bit e);
        m_done = 0;
        if (r) begin
            m_q = 0; m_rel = 0; m_mode = 0; m_run = 0;
        end else if (ld) begin
            m_q = v; m_rel = v; m_mode = ar; m_run = (v != 0);
        end else if (m_run && e) begin
            if (m_q == 1) begin
                m_done = 1;
                if (m_mode) m_q = m_rel;
                else begin m_q = 0; m_run = 0; end
            end else begin
                m_q = m_q - 1;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit ld, input int v,
                       input bit ar, input bit e);
        rst = r; load = ld; load_val = W'(v);
        auto_reload = ar; en = e;
        @(posedge clk);
        model(r, ld, v, ar, e);
        #1;
        chk("m_q", int'(q), m_q);
        chk("m_busy", int'(busy), int'(m_run));
        chk("m_done", int'(done), m_done);
        chk("m_zero", int'(zero), int'(m_q == 0));
    endtask

    int ens[5] = '{1, 0, 1, 0, 1};
    int gq[5]  = '{2, 2, 1, 1, 0};

    initial begin
        rst = 0; load = 0; load_val = '0; auto_reload = 0; en = 0;
        m_q = 0; m_rel = 0; m_mode = 0; m_run = 0; m_done = 0;

        // reset with load held high: load is ignored
        cyc(1, 1, 7, 0, 0);
        cyc(1, 1, 7, 0, 0);
        chk("rst_q", int'(q), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_zero", int'(zero), 1);

        // one-shot load 5
        cyc(0, 1, 5, 0, 1);
        chk("os_load_q", int'(q), 5);
        chk("os_load_busy", int'(busy), 1);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("os_q", int'(q), 5 - i);
            chk("os_done", int'(done), int'(i == 5));
            chk("os_busy", int'(busy), int'(i < 5));
        end
        cyc(0, 0, 0, 0, 1);
        chk("os_hold_q", int'(q), 0);
        chk("os_hold_done", int'(done), 0);

        // gated enable
        cyc(0, 1, 3, 0, 1);
        chk("g_load_q", int'(q), 3);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, bit'(ens[i]));
            chk("g_q", int'(q), gq[i]);
            chk("g_done", int'(done), int'(i == 4));
        end

        // auto-reload period 3
        cyc(0, 1, 3, 1, 1);
        chk("ar_load_q", int'(q), 3);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("ar_q", int'(q), 3 - ((i + 1) % 3));
            chk("ar_done", int'(done), int'((i % 3) == 2));
            chk("ar_busy", int'(busy), 1);
        end

        // restart, zero load, max load
        cyc(0, 1, 5, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
        chk("rs_q2", int'(q), 2);
        cyc(0, 1, 9, 0, 1);
        chk("rs_q9", int'(q), 9);
        chk("rs_done", int'(done), 0);
        cyc(0, 1, 0, 0, 1);
        chk("z_q", int'(q), 0);
        chk("z_busy", int'(busy), 0);
        chk("z_done", int'(done), 0);
        cyc(0, 1, 15, 0, 1);
        chk("mx_q", int'(q), 15);
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("mx_q", int'(q), 15 - i);
            chk("mx_done", int'(done), int'(i == 15));
        end

        // simultaneous events
        cyc(0, 1, 6, 1, 1);
        cyc(1, 1, 9, 1, 1);
        chk("rl_q", int'(q), 0);
        chk("rl_busy", int'(busy), 0);
        cyc(0, 1, 2, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("r1_q", int'(q), 1);
        cyc(1, 0, 0, 0, 1);
        chk("r1_done", int'(done), 0);
        chk("r1_q0", int'(q), 0);

        // divide-by-1
        cyc(0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1);
            chk("d1_q", int'(q), 1);
            chk("d1_done", int'(done), 1);
        end

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cyc(bit'($urandom_range(0, 63) == 0),
                bit'($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 15)),
                bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
